// File: rtl/dmshr_pkg.sv
// Shared types for the data-side MSHR: memory interface widths, command encoding,
// and the per-entry record tracked by the MSHR file.
package dmshr_pkg;

  localparam int DMSHR_NUM_ENTRIES = 8;
  localparam int DMSHR_PORTS       = 2;
  localparam int BLOCK_ADDR_W      = 29;
  localparam int MEM_TAG_W         = 4;
  localparam int MEM_BLOCK_W       = 64;
  localparam int ADDR_W            = 32;
  localparam int MEM_COMMAND_W     = 2;

  typedef logic [MEM_TAG_W-1:0]    mem_tag_t;
  typedef logic [MEM_BLOCK_W-1:0]  mem_block_t;
  typedef logic [BLOCK_ADDR_W-1:0] block_addr_t;

  typedef enum logic [MEM_COMMAND_W-1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } mem_command_t;

  // WAIT_TAG is reserved for a split command/tag handshake and is never entered.
  typedef enum logic [1:0] {
    DMSHR_INVALID   = 2'h0,
    DMSHR_PENDING   = 2'h1,
    DMSHR_WAIT_TAG  = 2'h2,
    DMSHR_WAIT_DATA = 2'h3
  } dmshr_state_t;

  typedef struct packed {
    dmshr_state_t state;
    block_addr_t  addr;
    mem_tag_t     tag;
  } dmshr_entry_t;

endpackage

// File: rtl/dmshr_alloc_select.sv
// Per-cycle allocation selector: merges duplicate misses and hands out the
// lowest free entries to the allocation ports in port order.
module dmshr_alloc_select
  import dmshr_pkg::*;
#(
  parameter int N           = DMSHR_PORTS,
  parameter int NUM_ENTRIES = DMSHR_NUM_ENTRIES,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [N-1:0]                               alloc_valid,
  input  logic [N-1:0][BLOCK_ADDR_W-1:0]             alloc_addr,
  input  logic [NUM_ENTRIES-1:0]                     entry_busy,
  input  logic [NUM_ENTRIES-1:0][BLOCK_ADDR_W-1:0]   entry_addr,
  output logic [N-1:0]                               alloc_accept,
  output logic [N-1:0]                               new_valid,
  output logic [N-1:0][IDX_W-1:0]                    new_idx
);

  logic [NUM_ENTRIES-1:0] claimed;
  logic                   hit;
  logic                   found;

  // An earlier port only counts as a merge target if it was itself accepted,
  // otherwise a rejected miss would silently swallow a later duplicate.
  always_comb begin
    claimed      = '0;
    alloc_accept = '0;
    new_valid    = '0;
    new_idx      = '0;
    hit          = 1'b0;
    found        = 1'b0;
    for (int p = 0; p < N; p++) begin
      hit   = 1'b0;
      found = 1'b0;
      if (alloc_valid[p]) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (entry_busy[e] && (entry_addr[e] == alloc_addr[p])) begin
            hit = 1'b1;
          end
        end
        for (int q = 0; q < p; q++) begin
          if (alloc_accept[q] && (alloc_addr[q] == alloc_addr[p])) begin
            hit = 1'b1;
          end
        end
        if (hit) begin
          alloc_accept[p] = 1'b1;
        end else begin
          for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (!found && !entry_busy[e] && !claimed[e]) begin
              found           = 1'b1;
              claimed[e]      = 1'b1;
              alloc_accept[p] = 1'b1;
              new_valid[p]    = 1'b1;
              new_idx[p]      = IDX_W'(e);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/dmshr.sv
// Data-side miss status holding registers: tracks outstanding dcache block misses,
// issues MEM_LOADs one per cycle and returns fill blocks matched by memory tag.
module dmshr
  import dmshr_pkg::*;
#(
  parameter int NUM_ENTRIES = DMSHR_NUM_ENTRIES,
  parameter int N           = DMSHR_PORTS
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N-1:0]                          alloc_valid,
  input  logic [N-1:0][BLOCK_ADDR_W-1:0]        alloc_addr,
  output logic [N-1:0]                          alloc_accept,
  input  logic [MEM_TAG_W-1:0]                  Dmem2proc_transaction_tag,
  input  logic [MEM_BLOCK_W-1:0]                Dmem2proc_data,
  input  logic [MEM_TAG_W-1:0]                  Dmem2proc_data_tag,
  output logic [MEM_COMMAND_W-1:0]              proc2Dmem_command,
  output logic [ADDR_W-1:0]                     proc2Dmem_addr,
  output logic                                  dcache_request,
  output logic                                  fill_valid,
  output logic [BLOCK_ADDR_W-1:0]               fill_addr,
  output logic [MEM_BLOCK_W-1:0]                fill_data,
  output logic                                  full,
  output dmshr_entry_t [NUM_ENTRIES-1:0]        dmshr_entries_debug
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  dmshr_entry_t [NUM_ENTRIES-1:0]               entries;
  dmshr_entry_t [NUM_ENTRIES-1:0]               entries_next;
  logic [NUM_ENTRIES-1:0]                       entry_busy;
  logic [NUM_ENTRIES-1:0][BLOCK_ADDR_W-1:0]     entry_addr;
  logic [N-1:0]                                 new_valid;
  logic [N-1:0][IDX_W-1:0]                      new_idx;
  logic                                         issue_valid;
  logic [IDX_W-1:0]                             issue_idx;
  logic [IDX_W-1:0]                             fill_idx;

  always_comb begin
    entry_busy = '0;
    entry_addr = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      entry_busy[e] = (entries[e].state != DMSHR_INVALID);
      entry_addr[e] = entries[e].addr;
    end
  end

  dmshr_alloc_select #(
    .N           (N),
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_alloc_select (
    .alloc_valid  (alloc_valid),
    .alloc_addr   (alloc_addr),
    .entry_busy   (entry_busy),
    .entry_addr   (entry_addr),
    .alloc_accept (alloc_accept),
    .new_valid    (new_valid),
    .new_idx      (new_idx)
  );

  // Issue and fill both look only at registered state, so a tag granted this
  // cycle can never be matched by a data tag in the same cycle.
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    fill_valid  = 1'b0;
    fill_idx    = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (!issue_valid && (entries[e].state == DMSHR_PENDING)) begin
        issue_valid = 1'b1;
        issue_idx   = IDX_W'(e);
      end
      if (!fill_valid && (Dmem2proc_data_tag != '0) &&
          (entries[e].state == DMSHR_WAIT_DATA) &&
          (entries[e].tag == Dmem2proc_data_tag)) begin
        fill_valid = 1'b1;
        fill_idx   = IDX_W'(e);
      end
    end
  end

  always_comb begin
    proc2Dmem_command   = issue_valid ? MEM_LOAD : MEM_NONE;
    proc2Dmem_addr      = issue_valid ? {entries[issue_idx].addr, 3'b000} : '0;
    dcache_request      = issue_valid;
    fill_addr           = fill_valid ? entries[fill_idx].addr : '0;
    fill_data           = fill_valid ? Dmem2proc_data : '0;
    full                = &entry_busy;
    dmshr_entries_debug = entries;
  end

  // Issue touches a PENDING entry, fill a WAIT_DATA entry and allocation an
  // INVALID one, so the three updates never collide on the same entry.
  always_comb begin
    entries_next = entries;
    if (issue_valid && (Dmem2proc_transaction_tag != '0)) begin
      entries_next[issue_idx].state = DMSHR_WAIT_DATA;
      entries_next[issue_idx].tag   = Dmem2proc_transaction_tag;
    end
    if (fill_valid) begin
      entries_next[fill_idx].state = DMSHR_INVALID;
      entries_next[fill_idx].addr  = '0;
      entries_next[fill_idx].tag   = '0;
    end
    for (int p = 0; p < N; p++) begin
      if (new_valid[p]) begin
        entries_next[new_idx[p]].state = DMSHR_PENDING;
        entries_next[new_idx[p]].addr  = alloc_addr[p];
        entries_next[new_idx[p]].tag   = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries <= '0;
    end else begin
      entries <= entries_next;
    end
  end

endmodule

// File: doc/dmshr.md
Name: dmshr

Overview:
- Data-side miss status holding register file, sitting between the dcache tag/data arrays and the shared memory port.
- Takes up to `N block-miss allocations per cycle from the dcache and merges duplicates.
- Issues MEM_LOAD requests to memory, one per cycle, matches returned transaction/data tags to entries, and presents fill blocks back to the dcache.
- Its request line feeds the icache/dcache memory arbitration as dcache_request.

Parameters:
NUM_ENTRIES, 8, number of MSHR entries
N, `N, allocation ports per cycle

Ports:
clock  in  1  system clock
reset  in  1  reset; one clock, reset is asynchronous and active-high
alloc_valid  in  N  miss allocation request per port
alloc_addr  in  N x 29  block address (addr[31:3])
alloc_accept  out  N  request accepted (new entry or merged)
Dmem2proc_transaction_tag  in  MEM_TAG  nonzero = memory accepted this cycle's command
Dmem2proc_data  in  MEM_BLOCK  returned block
Dmem2proc_data_tag  in  MEM_TAG  nonzero = Dmem2proc_data valid for that tag
proc2Dmem_command  out  MEM_COMMAND  MEM_NONE or MEM_LOAD
proc2Dmem_addr  out  ADDR  {block_addr, 3'b0}
dcache_request  out  1  high whenever proc2Dmem_command != MEM_NONE
fill_valid  out  1  fill block present this cycle
fill_addr  out  29  block address of fill
fill_data  out  MEM_BLOCK  fill block
full  out  1  no INVALID entry this cycle
dmshr_entries_debug  out  NUM_ENTRIES x DMSHR_ENTRY  under CPU_DEBUG_OUT

Behaviour:
- Entry fields: state, block addr, transaction_tag.
- States: DMSHR_INVALID, DMSHR_PENDING (allocated, not yet accepted by memory), DMSHR_WAIT_DATA (tag held).
- Reset: all entries INVALID, tags 0.
- Reset outputs: proc2Dmem_command=MEM_NONE, proc2Dmem_addr=0, dcache_request=0, fill_valid=0, fill_addr=0, fill_data=0, alloc_accept=0, full=0.
- Allocation (combinational accept, state update at next edge):
  - Ports are processed in order 0..N-1.
  - If alloc_addr matches a non-INVALID entry, or an earlier port this cycle: accept, no new entry (merge).
  - Otherwise take the lowest-index INVALID entry not already claimed this cycle: accept, entry -> PENDING next cycle.
  - No free entry: alloc_accept=0 for that port; later ports may still merge.
- An entry freed by a fill this cycle is not reusable until the next cycle.
- An allocation matching the entry filling this cycle is accepted as a merge, with no new entry.
- Issue:
  - Lowest-index PENDING entry drives proc2Dmem_command=MEM_LOAD, proc2Dmem_addr, dcache_request=1 combinationally.
  - Earliest issue is the cycle after allocation.
  - If Dmem2proc_transaction_tag != 0 the same cycle: entry -> WAIT_DATA, store tag.
  - If 0 (memory busy or arbiter lost): stays PENDING and retries next cycle.
- Fill:
  - When Dmem2proc_data_tag != 0 and equals a WAIT_DATA entry's tag: fill_valid=1, fill_addr/fill_data driven combinationally in that same cycle; entry -> INVALID at the edge.
  - A nonmatching data tag is ignored.
  - An entry that got its transaction tag this cycle cannot fill in the same cycle.
  - At most one fill per cycle; in-flight tags are unique.
- Simultaneous issue, fill and allocation in one cycle are independent and all are allowed.
- full reflects current-cycle state before allocations.
- Reset mid-operation: all entries invalidated asynchronously; later data tags from old transactions are ignored.

Decomposition:
- sys_defs.svh: DMSHR_STATE enum (INVALID, PENDING, WAIT_TAG reserved, WAIT_DATA) and DMSHR_ENTRY struct; MEM_TAG/MEM_BLOCK/MEM_COMMAND reused.
- One sub-module, dmshr_alloc_select: N-way free-entry/merge selector (priority encoder with claimed-mask chaining).

Test Plan:
- Single miss, accepted first try:
  - Alloc addr 0x1 port0 at cycle 0 -> alloc_accept=01.
  - Cycle 1: MEM_LOAD, proc2Dmem_addr=0x8, dcache_request=1; transaction_tag=1 given.
  - Cycles 2-4: MEM_NONE.
  - Data_tag=1, data=1 -> fill_valid=1, fill_addr=0x1, fill_data=1 same cycle; entry INVALID next cycle.
- Retry on transaction tag 0: tag=0 on first issue cycle -> MEM_LOAD 0x8 repeats next cycle; tag=3 -> WAIT_DATA with tag 3.
- Merge: both ports alloc addr 0x5 same cycle -> alloc_accept=11, exactly one entry PENDING, single MEM_LOAD 0x28.
- Full: eight distinct allocations (addrs 0..7) held in WAIT_DATA -> full=1. Ninth addr 0x9 -> alloc_accept=0; addr 0x3 -> accept (merge).
- Interleaved fills: entries with tags 2 and 5; data_tag=5 first -> fill_addr of tag-5 entry only; data_tag=7 -> fill_valid=0, no state change.
- Reset mid-operation: assert reset with two WAIT_DATA entries, deassert, drive data_tag=their tag -> fill_valid=0, all entries INVALID.
